p2s_serializer: RTL

//  Parametrised parallel-to-serial converter for the main-board FPGA; one instance replaces the fixed 24/16-bit

---
 rtl/p2s_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/p2s_serializer.sv
// p2s_serializer: parameterised parallel-to-serial converter with bit clock, frame sync and idle gap
//
// Accepts a word on load & ready, shifts out L bits (L = nbits, or DATA_W when nbits is 0 or too large),
// each bit held DIV clk cycles, then idles GAP_CYC cycles before pulsing done and returning to IDLE.
//
// Ports:
//   clk    in   1       system clock, rising edge
//   rst_n  in   1       asynchronous active-low reset
//   pdata  in   DATA_W  parallel word, bits [L-1:0] used
//   nbits  in   LEN_W   bits per frame, sampled with pdata
//   load   in   1       word valid, accepted when ready
//   ready  out  1       high only in IDLE
//   sdata  out  1       registered serial data
//   sclk   out  1       bit clock, low first half of a bit, high second half
//   sync   out  1       high during the whole SHIFT phase
//   busy   out  1       high in SHIFT and GAP
//   done   out  1       one-cycle pulse when the frame ends
module p2s_serializer #(
    parameter int DATA_W    = 24,
    parameter int LEN_W     = 5,
    parameter int DIV       = 4,
    parameter int GAP_CYC   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pdata,
    input  logic [LEN_W-1:0]  nbits,
    input  logic              load,
    output logic              ready,
    output logic              sdata,
    output logic              sclk,
    output logic              sync,
    output logic              busy,
    output logic              done
);
    localparam int DW = $clog2(DIV);
    localparam int GW = $clog2(GAP_CYC) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t            r_state, w_state;
    logic [DATA_W-1:0] r_shreg, w_shreg;
    logic [LEN_W-1:0]  r_bitcnt, w_bitcnt, w_len;
    logic [DW-1:0]     r_divcnt, w_divcnt;
    logic [GW-1:0]     r_gapcnt, w_gapcnt;
    logic              w_first;
    always_comb w_len = (nbits == '0 || nbits > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : nbits;
    // MSB-first words are left-aligned so the first bit sits at the top and unused upper bits fall off;
    // LSB-first words shift right, so bits above L-1 never reach bit 0 within L shifts.
    always_comb begin
        w_state  = r_state;
        w_shreg  = r_shreg;
        w_bitcnt = r_bitcnt;
        w_divcnt = r_divcnt;
        w_gapcnt = r_gapcnt;
        case (r_state)
            IDLE: if (load) begin
                w_state  = SHIFT;
                w_shreg  = MSB_FIRST ? pdata << (LEN_W'(DATA_W) - w_len) : pdata;
                w_bitcnt = w_len - 1'b1;
                w_divcnt = '0;
            end
            SHIFT: if (r_divcnt == DW'(DIV - 1)) begin
                w_divcnt = '0;
                if (r_bitcnt == '0) begin
                    w_state  = GAP;
                    w_gapcnt = '0;
                end else begin
                    w_bitcnt = r_bitcnt - 1'b1;
                    w_shreg  = MSB_FIRST ? r_shreg << 1 : r_shreg >> 1;
                end
            end else begin
                w_divcnt = r_divcnt + 1'b1;
            end
            GAP: if (r_gapcnt == GW'(GAP_CYC - 1)) w_state = IDLE;
                 else w_gapcnt = r_gapcnt + 1'b1;
            default: w_state = IDLE;
        endcase
    end
    always_comb w_first = MSB_FIRST ? w_shreg[DATA_W-1] : w_shreg[0];
    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_divcnt <= '0;
            r_gapcnt <= '0;
            ready    <= 1'b1;
            sdata    <= 1'b0;
            sclk     <= 1'b0;
            sync     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shreg  <= w_shreg;
            r_bitcnt <= w_bitcnt;
            r_divcnt <= w_divcnt;
            r_gapcnt <= w_gapcnt;
            ready    <= w_state == IDLE;
            sdata    <= (w_state == SHIFT) && w_first;
            sclk     <= (w_state == SHIFT) && (w_divcnt >= DW'(DIV / 2));
            sync     <= w_state == SHIFT;
            busy     <= w_state != IDLE;
            done     <= (r_state == GAP) && (w_state == IDLE);
        end
    end
endmodule
